uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial UART transmit stage, driven directly by the receive-to-transmit coupling block in the FPGA UART design. It accepts a byte and a level start flag, serialises it as one 8-bit frame: start bit, 8 data bits LSB-first, optional parity, one stop bit. It returns a one-cycle end-of-frame pulse that the coupling block uses to release its start flag and re-enable the receiver.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be ≥ 2)
- clc  input  1  system clock, all logic on rising edge
- res  input  1  reset; one clock; reset is synchronous and active-high
- TRANSMITTER_PRIZNAK  input  1  start request level from coupling block; held high until end pulse seen
- word_transmitter  input  8  byte to send; valid while TRANSMITTER_PRIZNAK high
- tx  output  1  serial line, idle high
- busy  output  1  high while a frame is in progress
- priznak_end_transmitter  output  1  one-cycle pulse, frame complete

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- Registers: start_prev (last sampled TRANSMITTER_PRIZNAK), shift[7:0], bit_idx[2:0], baud_cnt (width $clog2(CLKS_PER_BIT)), parity accumulator.
- Acceptance: in IDLE, TRANSMITTER_PRIZNAK==1 && start_prev==0 (rising edge) → latch word_transmitter into shift, baud_cnt=0, bit_idx=0, tx=0, busy=1, go START.
- start_prev updates every cycle regardless of state.
- Each bit lasts exactly CLKS_PER_BIT cycles. baud_cnt counts 0..CLKS_PER_BIT-1. On reaching CLKS_PER_BIT-1, it wraps to 0 and advances.
- START → DATA: tx=shift[0].
- DATA: on each bit boundary, shift right and bit_idx++. After bit_idx==7, go STOP (tx=1), or PARITY when enabled.
- STOP: at end of stop bit → IDLE, busy=0, priznak_end_transmitter=1 for that single cycle, tx stays 1.
- Rising edges of TRANSMITTER_PRIZNAK while busy are ignored and not queued.
- A start level held high across the end pulse does not retrigger; it must drop and rise again.
- word_transmitter changes after acceptance do not affect the frame in flight.

## Timing
- Reset values: tx=1, busy=0, priznak_end_transmitter=0, state IDLE, start_prev=1. A start level high through reset is not accepted until it goes low then high.
- Reset mid-frame: next edge returns to reset values, tx=1 immediately. The frame is aborted and no end pulse is issued.
- Acceptance edge N: tx=0 and busy=1 are visible after edge N.
- Data bit k (0..7) drives tx from edge N+(k+1)·CLKS_PER_BIT.
- Stop bit starts at edge N+9·CLKS_PER_BIT, or N+10·CLKS_PER_BIT with parity.
- End pulse and busy=0 occur at edge N+10·CLKS_PER_BIT, or N+11·CLKS_PER_BIT with parity.
- Earliest next acceptance is at the edge after a low sample of the start flag, following the end pulse.
- The coupling block drops its flag one cycle after the end pulse, so back-to-back frames are spaced ≥ 2 idle cycles.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state inserted after bit 7.
  - tx = XOR of all 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame is 11 bit times.
- Not defined: no parity state; frame is 10 bit times.

## Test plan
Use CLK_FREQ=16, BAUD=4 (CLKS_PER_BIT=4).
- Reset held 3 cycles with TRANSMITTER_PRIZNAK=1 → tx=1, busy=0, no frame after release until the flag toggles low then high.
- Send 0xA5, macro off → tx = 0 ×4 cycles, then 1,0,1,0,0,1,0,1 each ×4 cycles, then 1 ×4 cycles. End pulse exactly 1 cycle at acceptance+40.
- Send 0x03 with UART_TX_PARITY_EN → parity bit 0. Send 0x07 → parity bit 1. End pulse at acceptance+44.
- Second rising edge at acceptance+12 while busy, and word_transmitter changed to 0xFF mid-frame → neither affects the frame. Only one end pulse is produced.
- res asserted at acceptance+20 → tx=1, busy=0 next cycle, no end pulse. A new 0x5A request afterwards transmits correctly.
- Model the coupling block (flag dropped 1 cycle after end pulse) with two back-to-back bytes 0x11, 0x22 → two complete frames, each with a single end pulse.

Source files
------------

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if
// Purpose : coupling-block <-> UART transmitter handshake bundle.
// Signals : TRANSMITTER_PRIZNAK      start request level, held until end pulse seen
//           word_transmitter[7:0]    byte to send, valid while the start level is high
//           tx                       serial line, idle high
//           busy                     frame in progress
//           priznak_end_transmitter  one-cycle end-of-frame pulse
// Modports: master = coupling block, slave = transmitter.
interface uart_transmitter_if;
    logic       TRANSMITTER_PRIZNAK;
    logic [7:0] word_transmitter;
    logic       tx;
    logic       busy;
    logic       priznak_end_transmitter;

    modport master (
        output TRANSMITTER_PRIZNAK,
        output word_transmitter,
        input  tx,
        input  busy,
        input  priznak_end_transmitter
    );

    modport slave (
        input  TRANSMITTER_PRIZNAK,
        input  word_transmitter,
        output tx,
        output busy,
        output priznak_end_transmitter
    );
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter
// Purpose : serialises one byte per request as start bit, 8 data bits LSB-first,
//           optional even parity bit and one stop bit; pulses an end flag when done.
// Params  : CLK_FREQ, BAUD -> CLKS_PER_BIT = CLK_FREQ/BAUD (must be >= 2).
// Ports   : clc  system clock (rising edge)
//           res  synchronous active-high reset
//           bus  uart_transmitter_if.slave (start level, byte, tx, busy, end pulse)
// Macro   : UART_TX_PARITY_EN inserts an even-parity bit after data bit 7.
module uart_transmitter #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic              clc,
    input  logic              res,
    uart_transmitter_if.slave bus
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             r_state, w_state_nxt;
    logic               r_start_prev;
    logic [7:0]         r_shift, w_shift_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic [CNT_W-1:0]   r_baud_cnt, w_baud_cnt_nxt;
    logic               r_tx, w_tx_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_end, w_end_nxt;
    logic               w_bit_done;
`ifdef UART_TX_PARITY_EN
    logic               r_parity, w_parity_nxt;
`endif

    assign w_bit_done = (r_baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // State register
    always_ff @(posedge clc) begin
        if (res) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and next-register values
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_idx_nxt  = r_bit_idx;
        w_baud_cnt_nxt = r_baud_cnt;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_end_nxt      = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt   = r_parity;
`endif

        // Bit-time counter runs in every non-idle state
        if (r_state != IDLE)
            w_baud_cnt_nxt = w_bit_done ? '0 : CNT_W'(r_baud_cnt + 1'b1);

        case (r_state)
            IDLE: begin
                // Accept only a rising edge of the start level
                if (bus.TRANSMITTER_PRIZNAK && !r_start_prev) begin
                    w_shift_nxt    = bus.word_transmitter;
                    w_bit_idx_nxt  = 3'd0;
                    w_baud_cnt_nxt = '0;
                    w_tx_nxt       = 1'b0;
                    w_busy_nxt     = 1'b1;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt   = 1'b0;
`endif
                    w_state_nxt    = START;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_done) begin
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = r_parity ^ r_shift[0];
`endif
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_nxt    = r_parity ^ r_shift[0];
                        w_state_nxt = PARITY;
`else
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
`endif
                    end else begin
                        // Present the next bit while shifting it into position 0
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_tx_nxt      = r_shift[1];
                        w_bit_idx_nxt = 3'(r_bit_idx + 3'd1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_done) begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (w_bit_done) begin
                    w_tx_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_end_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output registers; start_prev resets high so a level held
    // through reset is not taken as a new request
    always_ff @(posedge clc) begin
        if (res) begin
            r_start_prev <= 1'b1;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_baud_cnt   <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_end        <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_start_prev <= bus.TRANSMITTER_PRIZNAK;
            r_shift      <= w_shift_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_baud_cnt   <= w_baud_cnt_nxt;
            r_tx         <= w_tx_nxt;
            r_busy       <= w_busy_nxt;
            r_end        <= w_end_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity     <= w_parity_nxt;
`endif
        end
    end

    assign bus.tx                      = r_tx;
    assign bus.busy                    = r_busy;
    assign bus.priznak_end_transmitter = r_end;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
// Purpose : directed, table-driven bench for uart_transmitter at CLKS_PER_BIT=4.
// Expected line patterns are hand-computed constants: bit i of 'line' is the
// level on tx during bit time i (start, d0..d7, [parity], stop).
// Macro   : UART_TX_PARITY_EN selects the 11-bit-time expectations.
module tb_uart_transmitter;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    typedef struct {
        logic [7:0]  data;
        logic [10:0] line;
    } vec_t;

    logic clk = 1'b0;
    logic res;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[6];

    uart_transmitter_if bus();

    uart_transmitter #(
        .CLK_FREQ(16),
        .BAUD    (4)
    ) dut (
        .clc(clk),
        .res(res),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Drives one request like the coupling block and checks every cycle of the frame.
    // glitch_at : cycle offset of an extra rising edge (with word change), -1 = none
    // abort_at  : cycle offset at which reset takes effect, -1 = none
    // hold_after: extra cycles the start level stays high after the end pulse
    task automatic send_frame(input logic [7:0] data, input logic [10:0] line,
                              input int glitch_at, input logic [7:0] late_word,
                              input int abort_at, input int hold_after);
        bus.TRANSMITTER_PRIZNAK = 1'b0;
        tick;
        bus.word_transmitter    = data;
        bus.TRANSMITTER_PRIZNAK = 1'b1;
        tick;
        for (int c = 0; c < int'(NBITS * CPB); c++) begin
            if (abort_at >= 0 && c == abort_at) begin
                chk("abort_tx",   bus.tx, 1'b1);
                chk("abort_busy", bus.busy, 1'b0);
                chk("abort_end",  bus.priznak_end_transmitter, 1'b0);
                res = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    tick;
                    chk("post_abort_tx",   bus.tx, 1'b1);
                    chk("post_abort_busy", bus.busy, 1'b0);
                    chk("post_abort_end",  bus.priznak_end_transmitter, 1'b0);
                end
                bus.TRANSMITTER_PRIZNAK = 1'b0;
                return;
            end
            chk("frame_tx",   bus.tx, line[c / CPB]);
            chk("frame_busy", bus.busy, 1'b1);
            chk("frame_end",  bus.priznak_end_transmitter, 1'b0);
            if (glitch_at >= 0 && c == glitch_at - 2)
                bus.TRANSMITTER_PRIZNAK = 1'b0;
            if (glitch_at >= 0 && c == glitch_at - 1) begin
                bus.TRANSMITTER_PRIZNAK = 1'b1;
                bus.word_transmitter    = late_word;
            end
            if (abort_at >= 0 && c == abort_at - 1)
                res = 1'b1;
            tick;
        end
        chk("end_pulse", bus.priznak_end_transmitter, 1'b1);
        chk("end_busy",  bus.busy, 1'b0);
        chk("end_tx",    bus.tx, 1'b1);
        for (int k = 0; k <= hold_after; k++) begin
            tick;
            chk("after_end",  bus.priznak_end_transmitter, 1'b0);
            chk("after_busy", bus.busy, 1'b0);
            chk("after_tx",   bus.tx, 1'b1);
        end
        bus.TRANSMITTER_PRIZNAK = 1'b0;
    endtask

    initial begin
`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'hA5, 11'h54A};
        vecs[1] = '{8'h03, 11'h406};
        vecs[2] = '{8'h07, 11'h60E};
        vecs[3] = '{8'h00, 11'h400};
        vecs[4] = '{8'hFF, 11'h5FE};
        vecs[5] = '{8'h80, 11'h700};
`else
        vecs[0] = '{8'hA5, 11'h34A};
        vecs[1] = '{8'h03, 11'h206};
        vecs[2] = '{8'h07, 11'h20E};
        vecs[3] = '{8'h00, 11'h200};
        vecs[4] = '{8'hFF, 11'h3FE};
        vecs[5] = '{8'h80, 11'h300};
`endif

        // Reset with the start level already high
        res                     = 1'b1;
        bus.TRANSMITTER_PRIZNAK = 1'b1;
        bus.word_transmitter    = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("reset_tx",   bus.tx, 1'b1);
            chk("reset_busy", bus.busy, 1'b0);
            chk("reset_end",  bus.priznak_end_transmitter, 1'b0);
        end
        res = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("held_no_start_busy", bus.busy, 1'b0);
            chk("held_no_start_tx",   bus.tx, 1'b1);
        end

        // Table of plain frames
        for (int i = 0; i < 6; i++)
            send_frame(vecs[i].data, vecs[i].line, -1, 8'h00, -1, 0);

        // Rising edge while busy at +12 plus word change to 0xFF: frame unchanged
        send_frame(8'hA5, vecs[0].line, 12, 8'hFF, -1, 0);

        // Level held high across the end pulse must not retrigger
        send_frame(8'hA5, vecs[0].line, -1, 8'h00, -1, 5);

        // Reset mid-frame at +20, then a fresh request transmits correctly
        send_frame(8'hA5, vecs[0].line, -1, 8'h00, 20, 0);
`ifdef UART_TX_PARITY_EN
        send_frame(8'h5A, 11'h4B4, -1, 8'h00, -1, 0);
`else
        send_frame(8'h5A, 11'h2B4, -1, 8'h00, -1, 0);
`endif

        // Back-to-back frames paced by the coupling block
`ifdef UART_TX_PARITY_EN
        send_frame(8'h11, 11'h422, -1, 8'h00, -1, 0);
        send_frame(8'h22, 11'h444, -1, 8'h00, -1, 0);
`else
        send_frame(8'h11, 11'h222, -1, 8'h00, -1, 0);
        send_frame(8'h22, 11'h244, -1, 8'h00, -1, 0);
`endif

        tick;
        chk("final_idle_busy", bus.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
